// File: rtl/race_tree_sequencer.sv
// Two-lane drag-race start controller: staging, amber tree, foul detection,
// per-lane reaction timing in ms and winner selection. One race per reset.
//   state   | meaning
//   IDLE    | waiting for both lanes to stage
//   STAGING | both staged, counting the stage hold time
//   AMB1..3 | amber steps, fouls detected per lane
//   RACE    | greens on, ms timing, waiting for launches or timeout
//   DONE    | results held until reset
module race_tree_sequencer #(
  parameter int unsigned STAGE_CYCLES = 50_000_000,
  parameter int unsigned AMBER_CYCLES = 25_000_000,
  parameter int unsigned MS_CYCLES    = 50_000,
  parameter int unsigned RT_WIDTH     = 12
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                SB0,
  input  logic                SB1,
  output logic                A1,
  output logic                A2,
  output logic                A3,
  output logic                G0,
  output logic                G1,
  output logic                R0,
  output logic                R1,
  output logic [RT_WIDTH-1:0] RT0,
  output logic [RT_WIDTH-1:0] RT1,
  output logic                Win0,
  output logic                Win1,
  output logic                Done
);

  typedef enum logic [2:0] {IDLE, STAGING, AMB1, AMB2, AMB3, RACE, DONE} state_e;

  state_e              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d, pre_q, pre_d;
  logic [RT_WIDTH-1:0] ms_q, ms_d, rt0_q, rt0_d, rt1_q, rt1_d;
  logic a1_q, a1_d, a2_q, a2_d, a3_q, a3_d, g0_q, g0_d, g1_q, g1_d;
  logic r0_q, r0_d, r1_q, r1_d, win0_q, win0_d, win1_q, win1_d, done_q, done_d;
  logic fin0_q, fin0_d, fin1_q, fin1_d, to0_q, to0_d, to1_q, to1_d;

  function automatic logic [1:0] pick_winner(input logic e0, input logic e1,
                                             input logic [RT_WIDTH-1:0] t0,
                                             input logic [RT_WIDTH-1:0] t1);
    if (e0 && e1) return {t0 <= t1, t1 <= t0};
    return {e0, e1};
  endfunction

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      ms_q    <= '0;
      rt0_q   <= '0;
      rt1_q   <= '0;
      {a1_q, a2_q, a3_q, g0_q, g1_q, r0_q, r1_q} <= '0;
      {win0_q, win1_q, done_q, fin0_q, fin1_q, to0_q, to1_q} <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      ms_q    <= ms_d;
      rt0_q   <= rt0_d;
      rt1_q   <= rt1_d;
      {a1_q, a2_q, a3_q, g0_q, g1_q, r0_q, r1_q} <= {a1_d, a2_d, a3_d, g0_d, g1_d, r0_d, r1_d};
      {win0_q, win1_q, done_q, fin0_q, fin1_q, to0_q, to1_q} <=
        {win0_d, win1_d, done_d, fin0_d, fin1_d, to0_d, to1_d};
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    ms_d    = ms_q;
    rt0_d   = rt0_q;
    rt1_d   = rt1_q;
    {a1_d, a2_d, a3_d, g0_d, g1_d, r0_d, r1_d} = {a1_q, a2_q, a3_q, g0_q, g1_q, r0_q, r1_q};
    {win0_d, win1_d, done_d, fin0_d, fin1_d, to0_d, to1_d} =
      {win0_q, win1_q, done_q, fin0_q, fin1_q, to0_q, to1_q};
    unique case (state_q)
      IDLE: begin
        if (SB0 && SB1) begin
          state_d = STAGING;
          cnt_d   = '0;
        end
      end
      STAGING: begin
        if (!SB0 || !SB1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == STAGE_CYCLES - 1) begin
          state_d = AMB1;
          cnt_d   = '0;
          a1_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      AMB1, AMB2, AMB3: begin
        if (!SB0 && !r0_q) begin
          r0_d  = 1'b1;
          rt0_d = '0;
        end
        if (!SB1 && !r1_q) begin
          r1_d  = 1'b1;
          rt1_d = '0;
        end
        // A foul on the last AMB3 cycle is resolved before the launch decision.
        if (r0_d && r1_d) begin
          state_d = DONE;
          {a1_d, a2_d, a3_d} = '0;
          done_d  = 1'b1;
          win0_d  = 1'b0;
          win1_d  = 1'b0;
        end else if (cnt_q == AMBER_CYCLES - 1) begin
          cnt_d = '0;
          if (state_q == AMB1) begin
            state_d = AMB2;
            a1_d    = 1'b0;
            a2_d    = 1'b1;
          end else if (state_q == AMB2) begin
            state_d = AMB3;
            a2_d    = 1'b0;
            a3_d    = 1'b1;
          end else begin
            state_d = RACE;
            a3_d    = 1'b0;
            g0_d    = !r0_d;
            g1_d    = !r1_d;
            pre_d   = '0;
            ms_d    = '0;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RACE: begin
        if (!r0_q && !fin0_q && !SB0) begin
          rt0_d  = ms_q;
          fin0_d = 1'b1;
        end
        if (!r1_q && !fin1_q && !SB1) begin
          rt1_d  = ms_q;
          fin1_d = 1'b1;
        end
        // A launch on the timeout cycle still counts as a real capture.
        if (ms_q == '1) begin
          if (!r0_q && !fin0_d) begin
            rt0_d = '1;
            to0_d = 1'b1;
          end
          if (!r1_q && !fin1_d) begin
            rt1_d = '1;
            to1_d = 1'b1;
          end
        end
        if ((ms_q == '1) || ((r0_q || fin0_d) && (r1_q || fin1_d))) begin
          state_d = DONE;
          done_d  = 1'b1;
          {win0_d, win1_d} = pick_winner(!r0_q && !to0_d, !r1_q && !to1_d, rt0_d, rt1_d);
        end else if (pre_q == MS_CYCLES - 1) begin
          pre_d = '0;
          ms_d  = ms_q + 1'b1;
        end else begin
          pre_d = pre_q + 32'd1;
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
  end

  assign {A1, A2, A3, G0, G1, R0, R1} = {a1_q, a2_q, a3_q, g0_q, g1_q, r0_q, r1_q};
  assign RT0  = rt0_q;
  assign RT1  = rt1_q;
  assign Win0 = win0_q;
  assign Win1 = win1_q;
  assign Done = done_q;

endmodule

// File: tb/tb_race_tree_sequencer.sv
// Directed bench for race_tree_sequencer: expected race results are queued
// when each race is launched and popped when Done rises.
module tb_race_tree_sequencer;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       SB0 = 1'b0, SB1 = 1'b0;
  logic       A1, A2, A3, G0, G1, R0, R1, Win0, Win1, Done;
  logic [3:0] RT0, RT1;

  int total = 0;
  int bad   = 0;
  int n;
  logic seen;

  typedef struct packed {
    logic [3:0] rt0;
    logic [3:0] rt1;
    logic       w0, w1, r0, r1;
  } res_t;
  res_t sb_q[$];

  race_tree_sequencer #(.STAGE_CYCLES(8), .AMBER_CYCLES(4), .MS_CYCLES(2), .RT_WIDTH(4)) dut (
    .Clock(Clock), .Reset(Reset), .SB0(SB0), .SB1(SB1),
    .A1(A1), .A2(A2), .A3(A3), .G0(G0), .G1(G1), .R0(R0), .R1(R1),
    .RT0(RT0), .RT1(RT1), .Win0(Win0), .Win1(Win1), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return A1;
      1: return A2;
      2: return A3;
      3: return G0;
      default: return Done;
    endcase
  endfunction

  task automatic wait_for(input int which, input int limit, output int cnt);
    cnt = 0;
    while (sig(which) !== 1'b1 && cnt < limit) begin
      tick();
      cnt++;
    end
    chk($sformatf("wait_sig%0d", which), {31'd0, sig(which)}, 32'd1);
  endtask

  task automatic lamp_len(input int which, input string tag);
    int c = 0;
    while (sig(which) === 1'b1 && c < 50) begin
      tick();
      c++;
    end
    chk(tag, c, 4);
  endtask

  task automatic outputs_zero(input string tag);
    chk(tag, {14'd0, A1, A2, A3, G0, G1, R0, R1, RT0, RT1, Win0, Win1, Done}, 32'd0);
  endtask

  task automatic do_reset();
    SB0   = 1'b0;
    SB1   = 1'b0;
    Reset = 1'b0;
    tick();
    outputs_zero("reset_outputs");
    Reset = 1'b1;
  endtask

  task automatic check_done(input string tag);
    res_t e;
    chk({tag, "_done"}, {31'd0, Done}, 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_rt0"}, {28'd0, RT0}, {28'd0, e.rt0});
      chk({tag, "_rt1"}, {28'd0, RT1}, {28'd0, e.rt1});
      chk({tag, "_win"}, {30'd0, Win0, Win1}, {30'd0, e.w0, e.w1});
      chk({tag, "_red"}, {30'd0, R0, R1}, {30'd0, e.r0, e.r1});
    end
  endtask

  initial begin
    // Normal race
    do_reset();
    SB0 = 1'b1; SB1 = 1'b1;
    sb_q.push_back('{rt0: 4'd3, rt1: 4'd5, w0: 1'b1, w1: 1'b0, r0: 1'b0, r1: 1'b0});
    tick();
    wait_for(0, 50, n);
    chk("stage_len", n, 8);
    lamp_len(0, "a1_len");
    chk("a2_contig", {31'd0, A2}, 32'd1);
    lamp_len(1, "a2_len");
    lamp_len(2, "a3_len");
    chk("greens_on", {29'd0, G0, G1, A3}, 32'd6);
    repeat (6) tick();
    SB0 = 1'b0;
    repeat (4) tick();
    chk("not_done_one_lane", {31'd0, Done}, 32'd0);
    SB1 = 1'b0;
    wait_for(4, 50, n);
    chk("done_latency", n, 1);
    check_done("normal");
    SB0 = 1'b1; SB1 = 1'b1;
    repeat (3) tick();
    chk("done_hold", {24'd0, Done, G0, G1, RT0, Win0}, {24'd0, 1'b1, 1'b1, 1'b1, 4'd3, 1'b1});

    // Staging abort, then restage into a lane-1 foul during AMB2
    do_reset();
    SB0 = 1'b1; SB1 = 1'b1;
    tick();
    repeat (4) tick();
    SB1 = 1'b0;
    tick();
    seen = 1'b0;
    repeat (12) begin
      tick();
      seen = seen | A1;
    end
    chk("abort_no_amber", {31'd0, seen}, 32'd0);
    SB1 = 1'b1;
    sb_q.push_back('{rt0: 4'd1, rt1: 4'd0, w0: 1'b1, w1: 1'b0, r0: 1'b0, r1: 1'b1});
    tick();
    wait_for(0, 50, n);
    chk("restage_len", n, 8);
    lamp_len(0, "a1_len2");
    SB1 = 1'b0;
    tick();
    chk("foul1_red", {27'd0, R1, RT1}, {27'd0, 1'b1, 4'd0});
    wait_for(3, 50, n);
    chk("foul1_no_g1", {31'd0, G1}, 32'd0);
    repeat (3) tick();
    SB0 = 1'b0;
    wait_for(4, 50, n);
    chk("foul1_done_latency", n, 1);
    check_done("single_foul");
    chk("foul1_g1_final", {31'd0, G1}, 32'd0);

    // Double foul
    do_reset();
    SB0 = 1'b1; SB1 = 1'b1;
    sb_q.push_back('{rt0: 4'd0, rt1: 4'd0, w0: 1'b0, w1: 1'b0, r0: 1'b1, r1: 1'b1});
    tick();
    wait_for(0, 50, n);
    SB0 = 1'b0;
    tick();
    chk("foul0_red", {30'd0, R0, Done}, 32'd2);
    wait_for(2, 50, n);
    SB1 = 1'b0;
    tick();
    chk("dbl_amber_off", {29'd0, A1, A2, A3}, 32'd0);
    check_done("double_foul");

    // Tie
    do_reset();
    SB0 = 1'b1; SB1 = 1'b1;
    sb_q.push_back('{rt0: 4'd2, rt1: 4'd2, w0: 1'b1, w1: 1'b1, r0: 1'b0, r1: 1'b0});
    tick();
    wait_for(3, 60, n);
    repeat (5) tick();
    SB0 = 1'b0; SB1 = 1'b0;
    wait_for(4, 50, n);
    chk("tie_done_latency", n, 1);
    check_done("tie");

    // Timeout: lane 1 never launches
    do_reset();
    SB0 = 1'b1; SB1 = 1'b1;
    sb_q.push_back('{rt0: 4'd0, rt1: 4'd15, w0: 1'b1, w1: 1'b0, r0: 1'b0, r1: 1'b0});
    tick();
    wait_for(3, 60, n);
    tick();
    SB0 = 1'b0;
    wait_for(4, 100, n);
    chk("timeout_latency", n, 30);
    check_done("timeout");

    // Reset mid-race
    do_reset();
    SB0 = 1'b1; SB1 = 1'b1;
    tick();
    wait_for(1, 60, n);
    Reset = 1'b0;
    tick();
    outputs_zero("midreset_outputs");
    Reset = 1'b1;
    tick();
    wait_for(0, 50, n);
    chk("midreset_restage_len", n, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
